// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor signal bundle: lock/toggle inputs from the PLL, reset and status outputs.
// master = supervisor side, slave = PLL / system side.
interface pll_lock_supervisor_if;
    logic        pll_lock;
    logic        freq_tgl;
    logic        pll_reset;
    logic        sys_reset;
    logic        locked;
    logic        fail;
    logic [2:0]  retry_cnt;
    logic [7:0]  lost_cnt;
    logic [15:0] freq_cnt;
    logic        freq_ok;

    modport master (
        input  pll_lock, freq_tgl,
        output pll_reset, sys_reset, locked, fail, retry_cnt, lost_cnt, freq_cnt, freq_ok
    );

    modport slave (
        output pll_lock, freq_tgl,
        input  pll_reset, sys_reset, locked, fail, retry_cnt, lost_cnt, freq_cnt, freq_ok
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for a filtered stable lock, then releases sys_reset.
// Latency: pll_lock seen 2 cycles late via synchroniser; all outputs registered (1 cycle after decision).
// No backpressure: free-running control loop. Optional frequency cross-check under PLL_FREQ_CHECK_EN.
module pll_lock_supervisor #(
    parameter int PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 65536,
    parameter int FILTER_CYCLES = 4,
    parameter int MAX_RETRY     = 7,
    parameter int WIN_CYCLES    = 8192,
    parameter int EXP_EDGES     = 102,
    parameter int TOL_EDGES     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    pll_lock_supervisor_if.master  bus
);

    typedef enum logic [2:0] {
        ST_PULSE,
        ST_WAIT,
        ST_SETTLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam int TMR_MAX_A = (PULSE_CYCLES > LOCK_TIMEOUT) ? PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_MAX   = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int FLT_W     = $clog2(FILTER_CYCLES + 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [FLT_W-1:0]   filt_q, filt_d;
    logic [2:0]         retry_q, retry_d;
    logic [7:0]         lost_q, lost_d;
    logic               lock_meta_q, lock_s_q;
    logic               pll_reset_q, pll_reset_d;
    logic               sys_reset_q, sys_reset_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic               freq_loss;

`ifdef PLL_FREQ_CHECK_EN
    localparam int WIN_W = $clog2(WIN_CYCLES);

    logic [2:0]       tgl_sync_q, tgl_sync_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic [15:0]      freq_cnt_q, freq_cnt_d;
    logic             freq_ok_q, freq_ok_d;
    logic             bad_win_q, bad_win_d;
    logic             tgl_edge, win_end, in_tol;
    logic [15:0]      cnt_inc, diff;

    always_comb begin
        tgl_sync_d = {tgl_sync_q[1:0], bus.freq_tgl};
        tgl_edge   = tgl_sync_q[2] ^ tgl_sync_q[1];
        cnt_inc    = (tgl_edge && edge_cnt_q != 16'hFFFF) ? edge_cnt_q + 16'd1 : edge_cnt_q;
        win_end    = (win_q == WIN_W'(WIN_CYCLES - 1));
        win_d      = win_end ? '0 : win_q + WIN_W'(1);
        edge_cnt_d = win_end ? 16'd0 : cnt_inc;
        diff       = (cnt_inc >= 16'(EXP_EDGES)) ? cnt_inc - 16'(EXP_EDGES)
                                                 : 16'(EXP_EDGES) - cnt_inc;
        in_tol     = (diff <= 16'(TOL_EDGES));
        freq_cnt_d = win_end ? cnt_inc : freq_cnt_q;
        freq_ok_d  = win_end ? in_tol : freq_ok_q;
        // Only consecutive bad windows that both close inside RUN count as a loss.
        if (state_q != ST_RUN) begin
            bad_win_d = 1'b0;
        end else if (win_end) begin
            bad_win_d = !in_tol;
        end else begin
            bad_win_d = bad_win_q;
        end
        freq_loss = (state_q == ST_RUN) && win_end && !in_tol && bad_win_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgl_sync_q <= '0;
            win_q      <= '0;
            edge_cnt_q <= '0;
            freq_cnt_q <= '0;
            freq_ok_q  <= 1'b1;
            bad_win_q  <= 1'b0;
        end else begin
            tgl_sync_q <= tgl_sync_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            freq_cnt_q <= freq_cnt_d;
            freq_ok_q  <= freq_ok_d;
            bad_win_q  <= bad_win_d;
        end
    end

    assign bus.freq_cnt = freq_cnt_q;
    assign bus.freq_ok  = freq_ok_q;
`else
    localparam int unused_freq_cfg = WIN_CYCLES + EXP_EDGES + TOL_EDGES;
    logic unused_freq_tgl;

    assign unused_freq_tgl = bus.freq_tgl;
    assign freq_loss       = 1'b0;
    assign bus.freq_cnt    = 16'd0;
    assign bus.freq_ok     = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        filt_d  = filt_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            ST_PULSE: begin
                if (timer_q == TMR_W'(PULSE_CYCLES - 1)) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT: begin
                // The lock cycle seen here is the first of the stable run.
                if (lock_s_q) begin
                    state_d = ST_SETTLE;
                    timer_d = TMR_W'(1);
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q == 3'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_PULSE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end else if (timer_q >= TMR_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    filt_d  = '0;
                    retry_d = 3'd0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if ((!lock_s_q && filt_q == FLT_W'(FILTER_CYCLES - 1)) || freq_loss) begin
                    state_d = ST_PULSE;
                    timer_d = '0;
                    filt_d  = '0;
                    lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                end else if (!lock_s_q) begin
                    filt_d = filt_q + FLT_W'(1);
                end else begin
                    filt_d = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PULSE;
                timer_d = '0;
            end
        endcase

        pll_reset_d = (state_d == ST_PULSE);
        sys_reset_d = (state_d != ST_RUN);
        locked_d    = (state_d == ST_RUN);
        fail_d      = fail_q || (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PULSE;
            timer_q     <= '0;
            filt_q      <= '0;
            retry_q     <= 3'd0;
            lost_q      <= 8'd0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            filt_q      <= filt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            lock_meta_q <= bus.pll_lock;
            lock_s_q    <= lock_meta_q;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_reset = sys_reset_q;
    assign bus.locked    = locked_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_q;
    assign bus.lost_cnt  = lost_q;

endmodule
